// File: rtl/id_bypass_scoreboard_if.sv
// ID-stage bypass/interlock bundle: control, ID operand info, forward selects and stall.
// Carries o_stall_count only when ID_SCOREBOARD_PERF_EN is defined.
interface id_bypass_scoreboard_if #(
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int REG_ADDR_W = 5
);
   localparam int SEL_W = $clog2(DEPTH + 1);

   logic                          i_hold;
   logic                          i_flush;
   logic                          i_id_valid;
   logic [NUM_SRC*REG_ADDR_W-1:0] i_id_src;
   logic [NUM_SRC-1:0]            i_id_src_used;
   logic [REG_ADDR_W-1:0]         i_id_rd;
   logic                          i_id_reg_write;
   logic [SEL_W-1:0]              i_id_avail;
   logic [NUM_SRC*SEL_W-1:0]      o_forward_sel;
   logic                          o_stall;
`ifdef ID_SCOREBOARD_PERF_EN
   logic [31:0]                   o_stall_count;

   modport master (
      output i_hold, i_flush, i_id_valid, i_id_src, i_id_src_used,
             i_id_rd, i_id_reg_write, i_id_avail,
      input  o_forward_sel, o_stall, o_stall_count
   );
   modport slave (
      input  i_hold, i_flush, i_id_valid, i_id_src, i_id_src_used,
             i_id_rd, i_id_reg_write, i_id_avail,
      output o_forward_sel, o_stall, o_stall_count
   );
`else
   modport master (
      output i_hold, i_flush, i_id_valid, i_id_src, i_id_src_used,
             i_id_rd, i_id_reg_write, i_id_avail,
      input  o_forward_sel, o_stall
   );
   modport slave (
      input  i_hold, i_flush, i_id_valid, i_id_src, i_id_src_used,
             i_id_rd, i_id_reg_write, i_id_avail,
      output o_forward_sel, o_stall
   );
`endif
endinterface

// File: rtl/id_bypass_scoreboard.sv
// ID-stage bypass select and load-use interlock over a DEPTH-deep shadow of in-flight writers.
// Optional stall counter enabled by defining ID_SCOREBOARD_PERF_EN.
module id_bypass_scoreboard #(
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int REG_ADDR_W = 5
) (
   input logic                   i_clk,
   input logic                   i_reset,
   id_bypass_scoreboard_if.slave bus
);
   localparam int SEL_W = $clog2(DEPTH + 1);

   logic [DEPTH:1]        valid_q, valid_d;
   logic [DEPTH:1]        we_q, we_d;
   logic [REG_ADDR_W-1:0] rd_q [1:DEPTH];
   logic [REG_ADDR_W-1:0] rd_d [1:DEPTH];
   logic [SEL_W-1:0]      avail_q [1:DEPTH];
   logic [SEL_W-1:0]      avail_d [1:DEPTH];

   logic [NUM_SRC-1:0]       hazard;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic                     stall;
   logic                     issue;

   function automatic logic [SEL_W-1:0] clamp_avail(input logic [SEL_W-1:0] a);
      if (a == '0) return SEL_W'(1);
      if (int'(a) > DEPTH) return SEL_W'(DEPTH);
      return a;
   endfunction

   // Scan oldest to youngest so the youngest matching writer overrides.
   always_comb begin : lookup
      logic                  hit;
      int                    hit_k;
      logic [REG_ADDR_W-1:0] addr;
      hazard  = '0;
      fwd_sel = '0;
      hit     = 1'b0;
      hit_k   = 0;
      addr    = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         addr  = bus.i_id_src[s*REG_ADDR_W +: REG_ADDR_W];
         hit   = 1'b0;
         hit_k = 0;
         for (int k = DEPTH; k >= 1; k--) begin
            if (bus.i_id_src_used[s] && (addr != '0) && valid_q[k] && we_q[k] &&
                (rd_q[k] == addr)) begin
               hit   = 1'b1;
               hit_k = k;
            end
         end
         if (hit) begin
            if (hit_k >= int'(avail_q[hit_k])) fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(hit_k);
            else hazard[s] = 1'b1;
         end
      end
   end

   assign stall = bus.i_id_valid & ~bus.i_flush & (|hazard);
   assign issue = bus.i_id_valid & ~bus.i_flush & ~stall;

   assign bus.o_forward_sel = fwd_sel;
   assign bus.o_stall       = stall;

   always_comb begin : advance
      valid_d = valid_q;
      we_d    = we_q;
      rd_d    = rd_q;
      avail_d = avail_q;
      if (!bus.i_hold) begin
         for (int k = DEPTH; k >= 2; k--) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            rd_d[k]    = rd_q[k-1];
            avail_d[k] = avail_q[k-1];
         end
         valid_d[1] = issue;
         we_d[1]    = bus.i_id_reg_write & (bus.i_id_rd != '0);
         rd_d[1]    = bus.i_id_rd;
         avail_d[1] = clamp_avail(bus.i_id_avail);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) valid_q <= '0;
      else         valid_q <= valid_d;
   end

   // Payload fields are qualified by valid_q and need no reset.
   always_ff @(posedge i_clk) begin
      we_q    <= we_d;
      rd_q    <= rd_d;
      avail_q <= avail_d;
   end

`ifdef ID_SCOREBOARD_PERF_EN
   logic [31:0] stall_count_q, stall_count_d;

   assign stall_count_d = stall_count_q + ((stall & ~bus.i_hold) ? 32'd1 : 32'd0);

   always_ff @(posedge i_clk) begin
      if (i_reset) stall_count_q <= '0;
      else         stall_count_q <= stall_count_d;
   end

   assign bus.o_stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_id_bypass_scoreboard.sv
// Bench for id_bypass_scoreboard: directed scenarios plus randomized traffic against a
// list-of-in-flight-instructions model; a second instance covers NUM_SRC=3, DEPTH=5.
module tb_id_bypass_scoreboard;
   localparam int NS = 2, DP = 3, AW = 5, SW = 2;
   localparam int NSB = 3, DPB = 5, SWB = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_bypass_scoreboard_if #(.NUM_SRC(NS),  .DEPTH(DP),  .REG_ADDR_W(AW)) bus_a ();
   id_bypass_scoreboard_if #(.NUM_SRC(NSB), .DEPTH(DPB), .REG_ADDR_W(AW)) bus_b ();

   id_bypass_scoreboard #(.NUM_SRC(NS), .DEPTH(DP), .REG_ADDR_W(AW)) u_a (
      .i_clk(clk), .i_reset(rst), .bus(bus_a));
   id_bypass_scoreboard #(.NUM_SRC(NSB), .DEPTH(DPB), .REG_ADDR_W(AW)) u_b (
      .i_clk(clk), .i_reset(rst), .bus(bus_b));

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [AW-1:0] rd;
      bit            we;
      int            avail;
      int            stage;
   } rec_t;
   rec_t inflight[$];
   logic [31:0] m_count;

   logic [NS*SW-1:0]   last_sel;
   logic               last_stall;
   logic [NSB*SWB-1:0] last_b_sel;
   logic               last_b_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_eval(output logic [NS*SW-1:0] sel, output logic stall);
      bit hz = 0;
      sel = '0;
      for (int s = 0; s < NS; s++) begin
         logic [AW-1:0] addr;
         int best, bav;
         addr = bus_a.i_id_src[s*AW +: AW];
         best = 99;
         bav  = 0;
         if (bus_a.i_id_src_used[s] && addr != 0) begin
            foreach (inflight[i])
               if (inflight[i].we && inflight[i].rd == addr && inflight[i].stage < best) begin
                  best = inflight[i].stage;
                  bav  = inflight[i].avail;
               end
            if (best != 99) begin
               if (best >= bav) sel[s*SW +: SW] = SW'(best);
               else hz = 1;
            end
         end
      end
      stall = bus_a.i_id_valid && !bus_a.i_flush && hz;
   endtask

   task automatic model_advance(input logic stall);
      if (rst) begin
         inflight.delete();
         m_count = 0;
      end else if (!bus_a.i_hold) begin
         m_count += {31'd0, stall};
         foreach (inflight[i]) inflight[i].stage++;
         while (inflight.size() > 0 && inflight[0].stage > DP) void'(inflight.pop_front());
         if (bus_a.i_id_valid && !bus_a.i_flush && !stall) begin
            rec_t r;
            r.rd    = bus_a.i_id_rd;
            r.we    = bus_a.i_id_reg_write && (bus_a.i_id_rd != 0);
            r.avail = int'(bus_a.i_id_avail);
            if (r.avail == 0) r.avail = 1;
            if (r.avail > DP) r.avail = DP;
            r.stage = 1;
            inflight.push_back(r);
         end
      end
   endtask

   // One clock: sample/check at negedge, update the model at posedge, new inputs at +1.
   task automatic cyc(input string tag);
      logic [NS*SW-1:0] esel;
      logic             estall;
      @(negedge clk);
      model_eval(esel, estall);
      last_sel     = bus_a.o_forward_sel;
      last_stall   = bus_a.o_stall;
      last_b_sel   = bus_b.o_forward_sel;
      last_b_stall = bus_b.o_stall;
      if (!rst) begin
         check({tag, "_sel"}, 32'(last_sel), 32'(esel));
         check({tag, "_stall"}, 32'(last_stall), 32'(estall));
`ifdef ID_SCOREBOARD_PERF_EN
         check({tag, "_cnt"}, bus_a.o_stall_count, m_count);
`endif
      end
      @(posedge clk);
      model_advance(estall);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] used, input logic [AW-1:0] rd, input logic we,
                         input logic [SW-1:0] av, input logic hold, input logic flush);
      bus_a.i_id_valid     = v;
      bus_a.i_id_src       = {s1, s0};
      bus_a.i_id_src_used  = used;
      bus_a.i_id_rd        = rd;
      bus_a.i_id_reg_write = we;
      bus_a.i_id_avail     = av;
      bus_a.i_hold         = hold;
      bus_a.i_flush        = flush;
   endtask

   task automatic randomize_a(input bit allow_ctl);
      set_id(1'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             2'($urandom), AW'($urandom_range(0, 7)), 1'($urandom), SW'($urandom),
             allow_ctl && ($urandom_range(0, 99) < 15), allow_ctl && ($urandom_range(0, 99) < 10));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         set_id(0, 0, 0, 0, 0, 0, 1, 0, 0);
         cyc("idle");
      end
   endtask

   initial begin
      set_id(0, 0, 0, 0, 0, 0, 1, 0, 0);
      bus_b.i_hold = 0; bus_b.i_flush = 0; bus_b.i_id_valid = 0; bus_b.i_id_src = '0;
      bus_b.i_id_src_used = '0; bus_b.i_id_rd = '0; bus_b.i_id_reg_write = 0; bus_b.i_id_avail = '0;

      // Reset for two cycles with random inputs, then first cycle out of reset.
      rst = 1;
      randomize_a(1); cyc("rst0");
      randomize_a(1); cyc("rst1");
      rst = 0;
      set_id(1, 5, 6, 2'b11, 7, 1, 2, 0, 0);
      cyc("post_rst");
      check("post_rst_sel0", 32'(last_sel), 32'd0);
      check("post_rst_stall0", 32'(last_stall), 32'd0);
      idle(3);

      // ALU chain: producer rd=8 visible at EX, MEM, WB, then retired.
      set_id(1, 0, 0, 2'b00, 8, 1, 1, 0, 0); cyc("alu_issue");
      set_id(1, 8, 0, 2'b01, 0, 0, 1, 0, 0); cyc("alu_ex");
      check("alu_ex_c", 32'(last_sel[1:0]), 32'd1);
      cyc("alu_mem");
      check("alu_mem_c", 32'(last_sel[1:0]), 32'd2);
      cyc("alu_wb");
      check("alu_wb_c", 32'(last_sel[1:0]), 32'd3);
      cyc("alu_rf");
      check("alu_rf_c", 32'(last_sel[1:0]), 32'd0);
      idle(3);

      // Load-use: one stall bubble, then forward from MEM.
      set_id(1, 0, 0, 2'b00, 9, 1, 2, 0, 0); cyc("lw_issue");
      set_id(1, 0, 9, 2'b10, 12, 1, 1, 0, 0); cyc("lu_stall");
      check("lu_stall_c", 32'(last_stall), 32'd1);
      cyc("lu_fwd");
      check("lu_fwd_stall", 32'(last_stall), 32'd0);
      check("lu_fwd_sel1", 32'(last_sel[3:2]), 32'd2);
`ifdef ID_SCOREBOARD_PERF_EN
      check("lu_cnt_c", bus_a.o_stall_count, 32'd1);
`endif
      idle(3);

      // Youngest wins; register 0 and unused sources never match.
      set_id(1, 0, 0, 2'b00, 4, 1, 1, 0, 0); cyc("yw_w1");
      set_id(1, 0, 0, 2'b00, 4, 1, 1, 0, 0); cyc("yw_w2");
      set_id(1, 4, 0, 2'b01, 0, 0, 1, 0, 0); cyc("yw_use");
      check("yw_sel0", 32'(last_sel[1:0]), 32'd1);
      set_id(1, 0, 4, 2'b01, 0, 0, 1, 0, 0); cyc("yw_zero_unused");
      check("yw_zero_sel", 32'(last_sel), 32'd0);
      idle(3);

      // Hold during a load-use hazard: frozen, still stalling.
      set_id(1, 0, 0, 2'b00, 9, 1, 2, 0, 0); cyc("hold_lw");
      for (int i = 0; i < 3; i++) begin
         set_id(1, 9, 0, 2'b01, 0, 0, 1, 1, 0); cyc("hold_stall");
         check("hold_stall_c", 32'(last_stall), 32'd1);
      end
      set_id(1, 9, 0, 2'b01, 0, 0, 1, 0, 0); cyc("hold_release");
      cyc("hold_fwd");
      check("hold_fwd_sel0", 32'(last_sel[1:0]), 32'd2);
      idle(3);

      // Flush beats the hazard and leaves a bubble, not the flushed writer.
      set_id(1, 0, 0, 2'b00, 9, 1, 2, 0, 0); cyc("fl_lw");
      set_id(1, 9, 0, 2'b01, 9, 1, 1, 0, 1); cyc("fl_flush");
      check("fl_stall", 32'(last_stall), 32'd0);
      set_id(1, 9, 0, 2'b01, 0, 0, 1, 0, 0); cyc("fl_after");
      check("fl_after_sel0", 32'(last_sel[1:0]), 32'd2);
      idle(3);

      // Randomized traffic with occasional hold, flush and reset.
      for (int i = 0; i < 400; i++) begin
         randomize_a(1);
         rst = ($urandom_range(0, 99) < 2);
         cyc("rand");
      end
      rst = 0;
      idle(4);

      // Wider configuration: avail=4 with DEPTH=5 stalls three cycles, then forwards from stage 4.
      bus_b.i_id_valid = 1; bus_b.i_id_rd = 10; bus_b.i_id_reg_write = 1;
      bus_b.i_id_avail = 3'd4; bus_b.i_id_src_used = 3'b000;
      cyc("b_issue");
      bus_b.i_id_rd = 0; bus_b.i_id_reg_write = 0; bus_b.i_id_avail = 3'd1;
      bus_b.i_id_src = {5'd10, 5'd0, 5'd0}; bus_b.i_id_src_used = 3'b100;
      for (int i = 0; i < 3; i++) begin
         cyc("b_stall");
         check("b_stall_c", 32'(last_b_stall), 32'd1);
      end
      cyc("b_fwd");
      check("b_fwd_stall", 32'(last_b_stall), 32'd0);
      check("b_fwd_sel2", 32'(last_b_sel[8:6]), 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
